// File: rtl/memaccess_ctrl_pkg.sv
// Shared types and constants for the memory access controller.
//   req_type_e : request kinds as they arrive on req_type
//   state_e    : controller FSM states
//   MS_*       : encodings presented on mem_state
package memaccess_ctrl_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    REQ_LOAD      = 2'd0,
    REQ_LOAD_IND  = 2'd1,
    REQ_STORE     = 2'd2,
    REQ_STORE_IND = 2'd3
  } req_type_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_IND,
    S_IND_WAIT,
    S_RD,
    S_RD_WAIT,
    S_WR,
    S_DONE
  } state_e;

  localparam logic [1:0] MS_READ  = 2'd0;
  localparam logic [1:0] MS_WRITE = 2'd1;
  localparam logic [1:0] MS_IND   = 2'd2;
  localparam logic [1:0] MS_IDLE  = 2'd3;

  function automatic logic is_indirect(req_type_e t);
    return (t == REQ_LOAD_IND) || (t == REQ_STORE_IND);
  endfunction

  function automatic logic is_store(req_type_e t);
    return (t == REQ_STORE) || (t == REQ_STORE_IND);
  endfunction

endpackage

// File: rtl/memaccess_ctrl.sv
// Memory access controller: accepts one LOAD / LOAD_IND / STORE / STORE_IND
// request at a time and sequences the data-memory strobes for it. Indirect
// requests first read a pointer from the captured address and then use the
// returned word as the effective address.
//
// Ports
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   req_valid, req_ready  : request handshake (ready only while idle)
//   req_type              : 0=LOAD 1=LOAD_IND 2=STORE 3=STORE_IND
//   M_Addr, M_Data        : effective/pointer address and store data
//   DMem_addr/din/rd/wr   : memory request; DMem_dout returns one cycle after rd
//   mem_state             : 0=read 1=write 2=indirect read 3=idle
//   load_data             : last loaded word, held until the next load completes
//   done                  : one-cycle completion pulse
//   txn_count             : completed transactions, wraps at 16 bits
//
// State table
//   state      | meaning
//   S_IDLE     | waiting for a request, req_ready high
//   S_IND      | pointer read issued at captured address
//   S_IND_WAIT | pointer returns, becomes the effective address
//   S_RD       | data read issued at effective address
//   S_RD_WAIT  | read data returns into load_data
//   S_WR       | data write issued at effective address
//   S_DONE     | completion pulse, count update
module memaccess_ctrl
  import memaccess_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [1:0]        req_type,
  input  logic [ADDR_W-1:0] M_Addr,
  input  logic [DATA_W-1:0] M_Data,
  input  logic [DATA_W-1:0] DMem_dout,
  output logic              req_ready,
  output logic [1:0]        mem_state,
  output logic [ADDR_W-1:0] DMem_addr,
  output logic [DATA_W-1:0] DMem_din,
  output logic              DMem_rd,
  output logic              DMem_wr,
  output logic [DATA_W-1:0] load_data,
  output logic              done,
  output logic [15:0]       txn_count
);

  state_e            state_q, state_d;
  req_type_e         type_q;
  req_type_e         type_in;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;

  assign type_in = req_type_e'(req_type);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      type_q    <= REQ_LOAD;
      addr_q    <= '0;
      data_q    <= '0;
      load_data <= '0;
      txn_count <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            type_q <= type_in;
            addr_q <= M_Addr;
            data_q <= M_Data;
          end
        end
        // The pointer word replaces the captured address; the remainder of
        // the operation is then identical to a direct access.
        S_IND_WAIT: addr_q    <= ADDR_W'(DMem_dout);
        S_RD_WAIT:  load_data <= DMem_dout;
        S_DONE:     txn_count <= txn_count + 16'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    mem_state = MS_IDLE;
    DMem_addr = '0;
    DMem_din  = '0;
    DMem_rd   = 1'b0;
    DMem_wr   = 1'b0;
    done      = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (is_indirect(type_in))   state_d = S_IND;
          else if (is_store(type_in)) state_d = S_WR;
          else                        state_d = S_RD;
        end
      end
      S_IND: begin
        mem_state = MS_IND;
        DMem_addr = addr_q;
        DMem_rd   = 1'b1;
        state_d   = S_IND_WAIT;
      end
      S_IND_WAIT: begin
        mem_state = MS_IND;
        state_d   = is_store(type_q) ? S_WR : S_RD;
      end
      S_RD: begin
        mem_state = MS_READ;
        DMem_addr = addr_q;
        DMem_rd   = 1'b1;
        state_d   = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        mem_state = MS_READ;
        state_d   = S_DONE;
      end
      S_WR: begin
        mem_state = MS_WRITE;
        DMem_addr = addr_q;
        DMem_din  = data_q;
        DMem_wr   = 1'b1;
        state_d   = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
